seq_shift_issue_ctrl: RTL and testbench

Issue controller that sits directly upstream of `gate_level_seq_shifter` and owns its `start`/`done` protocol. It accepts shift requests from the processor datapath over a valid/ready handshake and drives `start`, `ctrl`, `shift_amt` and `data_in` into the shifter. It then waits for `done`, captures `data_out` and returns it with the request tag over a valid/ready response channel. It also bypasses zero-amount shifts and guards against a hung shifter with a timeout.

---
 rtl/seq_shift_issue_ctrl_if.sv | 43 ++++
 rtl/seq_shift_issue_ctrl.sv | 107 ++++++++++
 tb/tb_seq_shift_issue_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_issue_ctrl_if.sv
// Request, shifter-side and response signals of the shift issue controller, bundled as one port.
// slave = the controller itself; master = the processor-side producer/consumer plus the shifter.
interface seq_shift_issue_ctrl_if #(
    parameter int TAGW = 3
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [2:0]      req_amt;
    logic [7:0]      req_data;
    logic [TAGW-1:0] req_tag;

    logic            sh_start;
    logic [1:0]      sh_ctrl;
    logic [2:0]      sh_amt;
    logic [7:0]      sh_data;
    logic            sh_done;
    logic [7:0]      sh_result;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_data;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_err;

    modport slave (
        input  req_valid, req_op, req_amt, req_data, req_tag,
        input  sh_done, sh_result,
        input  rsp_ready,
        output req_ready,
        output sh_start, sh_ctrl, sh_amt, sh_data,
        output rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport master (
        output req_valid, req_op, req_amt, req_data, req_tag,
        output sh_done, sh_result,
        output rsp_ready,
        input  req_ready,
        input  sh_start, sh_ctrl, sh_amt, sh_data,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/seq_shift_issue_ctrl.sv
// Issues one shift at a time to the sequential shifter and returns its result with the tag.
// Latency: shifter latency + 3 (zero-amount bypass: 1); response held while rsp_ready is low.
module seq_shift_issue_ctrl #(
    parameter int TAGW    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_shift_issue_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [7:0]      r_cnt;
    logic            r_sh_start;
    logic [1:0]      r_sh_ctrl;
    logic [2:0]      r_sh_amt;
    logic [7:0]      r_sh_data;
    logic [7:0]      r_rsp_data;
    logic [TAGW-1:0] r_rsp_tag;
    logic            r_rsp_err;

    logic            w_req_ready;
    logic            w_accept;
    logic            w_timeout;

    assign w_req_ready = (r_state == S_IDLE);
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_timeout   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_sh_start <= 1'b0;
            r_sh_ctrl  <= 2'd0;
            r_sh_amt   <= 3'd0;
            r_sh_data  <= 8'd0;
            r_rsp_data <= 8'd0;
            r_rsp_tag  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sh_ctrl <= bus.req_op;
                        r_sh_amt  <= bus.req_amt;
                        r_sh_data <= bus.req_data;
                        r_rsp_tag <= bus.req_tag;
                        // A zero-amount shift is the identity for every op, so skip the shifter.
                        if (bus.req_amt == 3'd0) begin
                            r_rsp_data <= bus.req_data;
                            r_rsp_err  <= 1'b0;
                            r_state    <= S_RESP;
                        end else begin
                            r_sh_start <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_sh_start <= 1'b0;
                    r_cnt      <= 8'd0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over a timeout landing on the same edge.
                    if (bus.sh_done) begin
                        r_rsp_data <= bus.sh_result;
                        r_rsp_err  <= 1'b0;
                        r_state    <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_data <= 8'd0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.sh_start  = r_sh_start;
    assign bus.sh_ctrl   = r_sh_ctrl;
    assign bus.sh_amt    = r_sh_amt;
    assign bus.sh_data   = r_sh_data;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_tag   = r_rsp_tag;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_seq_shift_issue_ctrl.sv
// Bench for seq_shift_issue_ctrl: plays the processor and the sequential shifter, with an
// arithmetic shift reference and a cycle-count expectation for each request.
`timescale 1ns/1ps
module tb_seq_shift_issue_ctrl;
    localparam int TAGW    = 3;
    localparam int TIMEOUT = 16;
    localparam int HANG    = 255;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   starts;

    seq_shift_issue_ctrl_if #(.TAGW(TAGW)) bus ();

    seq_shift_issue_ctrl #(.TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [1:0] op, input int amt, input logic [7:0] d);
        logic [15:0] dd;
        case (op)
            2'd0:    return d << amt;
            2'd1:    return d >> amt;
            2'd2:    return 8'($signed(d) >>> amt);
            default: begin
                dd = {d, d} >> amt;
                return dd[7:0];
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.sh_start === 1'b1) starts++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sh_start"},  bus.sh_start, 0);
        chk({tag, "_sh_ctrl"},   bus.sh_ctrl, 0);
        chk({tag, "_sh_amt"},    bus.sh_amt, 0);
        chk({tag, "_sh_data"},   bus.sh_data, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_data"},  bus.rsp_data, 0);
        chk({tag, "_rsp_tag"},   bus.rsp_tag, 0);
        chk({tag, "_rsp_err"},   bus.rsp_err, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
    endtask

    // lat: cycles from the shifter seeing start to raising done; HANG = never.
    task automatic do_req(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data,
                          input logic [TAGW-1:0] tag, input int lat, input int hold, input bit stray);
        logic [7:0] exp_data;
        bit         exp_err;
        int         exp_n;
        int         n;
        bit         bad_ready;
        exp_err  = (amt != 0) && (lat > TIMEOUT - 1);
        exp_data = exp_err ? 8'h00 : ((amt == 0) ? data : ref_shift(op, int'(amt), data));
        exp_n    = (amt == 0) ? 0 : (exp_err ? TIMEOUT + 1 : lat + 2);
        starts    = 0;
        bad_ready = 0;

        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_amt   = amt;
        bus.req_data  = data;
        bus.req_tag   = tag;
        tick();
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_amt   = 3'($urandom);
        bus.req_data  = 8'($urandom);
        bus.req_tag   = TAGW'($urandom);

        if (amt != 0) begin
            chk("sh_ctrl", bus.sh_ctrl, op);
            chk("sh_amt",  bus.sh_amt, amt);
            chk("sh_data", bus.sh_data, data);
        end

        n = 0;
        while (!bus.rsp_valid && n < 300) begin
            if (bus.req_ready !== 1'b0) bad_ready = 1;
            bus.sh_done   = (amt != 0) && (lat != HANG) && (n == lat + 1);
            bus.sh_result = bus.sh_done ? ref_shift(bus.sh_ctrl, int'(bus.sh_amt), bus.sh_data)
                                        : 8'($urandom);
            tick();
            n++;
        end
        bus.sh_done = 1'b0;

        chk("latency",   n, exp_n);
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_data",  bus.rsp_data, exp_data);
        chk("rsp_err",   bus.rsp_err, exp_err);
        chk("rsp_tag",   bus.rsp_tag, tag);

        for (int i = 0; i < hold; i++) begin
            bus.rsp_ready = 1'b0;
            bus.sh_done   = stray;
            bus.sh_result = ~exp_data;
            tick();
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_data",  bus.rsp_data, exp_data);
            chk("hold_tag",   bus.rsp_tag, tag);
            chk("hold_err",   bus.rsp_err, exp_err);
        end
        bus.sh_done   = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", bus.rsp_valid, 0);
        chk("req_ready_back", bus.req_ready, 1);
        chk("start_pulses",   starts, (amt != 0) ? 1 : 0);
        chk("ready_inflight", bad_ready, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int seen_valid;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_amt   = 3'd0;
        bus.req_data  = 8'd0;
        bus.req_tag   = '0;
        bus.sh_done   = 1'b0;
        bus.sh_result = 8'd0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk_reset_outputs("rst1");

        // Directed vectors on 10110011.
        do_req(2'd0, 3'd1, 8'hB3, 3'd5, 1, 0, 0);
        do_req(2'd1, 3'd2, 8'hB3, 3'd1, 2, 0, 0);
        do_req(2'd2, 3'd3, 8'hB3, 3'd3, 3, 0, 0);
        do_req(2'd3, 3'd4, 8'hB3, 3'd7, 4, 0, 0);
        do_req(2'd3, 3'd0, 8'hA5, 3'd2, 1, 0, 0);
        do_req(2'd0, 3'd3, 8'h5C, 3'd4, HANG, 0, 0);
        do_req(2'd1, 3'd6, 8'hF0, 3'd6, 5, 0, 0);
        do_req(2'd2, 3'd1, 8'h81, 3'd3, 2, 5, 1);
        do_req(2'd3, 3'd7, 8'h3C, 3'd1, TIMEOUT - 1, 0, 0);
        do_req(2'd0, 3'd0, 8'h11, 3'd0, 1, 3, 1);
        do_req(2'd0, 3'd2, 8'hC3, 3'd5, HANG, 2, 1);

        for (int k = 0; k < 40; k++) begin
            do_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom),
                   TAGW'($urandom), ($urandom_range(0, 9) == 0) ? HANG : $urandom_range(1, TIMEOUT - 1),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset while waiting on a hung shifter.
        starts        = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd2;
        bus.req_amt   = 3'd5;
        bus.req_data  = 8'h96;
        bus.req_tag   = 3'd6;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1 chk_reset_outputs("midwait");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        starts     = 0;
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            bus.sh_done   = (i == 3);
            bus.sh_result = 8'h5A;
            tick();
            if (bus.rsp_valid !== 1'b0) seen_valid++;
        end
        bus.sh_done = 1'b0;
        chk("post_reset_rsp",   seen_valid, 0);
        chk("post_reset_start", starts, 0);
        do_req(2'd1, 3'd3, 8'h96, 3'd2, 3, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
